// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: fade/"breathe" envelope sequencer for the PWM duty input.
// Ramps duty from a low level up to a high level in fixed steps at a
// programmable tick rate, dwells at the peak, then ramps back down.
// Optional looping mode: define PWM_FADE_LOOP_EN to add the loop_en port and
// the HOLD_LOW dwell between repeated envelopes.
module pwm_fade_ctrl #(
   parameter int DUTY_W  = 8,
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
`ifdef PWM_FADE_LOOP_EN
   input  logic               loop_en,
`endif
   input  logic [DUTY_W-1:0]  duty_lo,
   input  logic [DUTY_W-1:0]  duty_hi,
   input  logic [DUTY_W-1:0]  step,
   input  logic [TIMER_W-1:0] interval,
   input  logic [TIMER_W-1:0] hold,
   output logic [DUTY_W-1:0]  duty,
   output logic               busy,
   output logic               done,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HIGH = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LOW  = 3'd4
   } state_e;

   state_e             state_q;
   logic [DUTY_W-1:0]  duty_q, lo_q, hi_q, step_q;
   logic [TIMER_W-1:0] intv_q, hold_q, tick_q, hcnt_q;
   logic               busy_q, done_q;

   logic [DUTY_W-1:0]  step_eff;
   logic [DUTY_W:0]    up_sum, dn_diff;
   logic [DUTY_W-1:0]  up_d, dn_d;
   logic               tick;

   // Next ramp levels: one extra bit catches carry/borrow so the level clamps
   // at hi/lo instead of wrapping.
   always_comb begin
      step_eff = (step_q == '0) ? DUTY_W'(1) : step_q;
      up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
      dn_diff  = {1'b0, duty_q} - {1'b0, step_eff};
      up_d     = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[DUTY_W-1:0];
      dn_d     = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] <= lo_q)) ? lo_q
                                                                    : dn_diff[DUTY_W-1:0];
      tick     = (tick_q == intv_q);
   end

   // Envelope FSM with registered duty/busy/done; abort overrides everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         duty_q  <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         step_q  <= '0;
         intv_q  <= '0;
         hold_q  <= '0;
         tick_q  <= '0;
         hcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            tick_q  <= '0;
            hcnt_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     lo_q   <= duty_lo;
                     hi_q   <= duty_hi;
                     step_q <= step;
                     intv_q <= interval;
                     hold_q <= hold;
                     tick_q <= '0;
                     hcnt_q <= '0;
                     duty_q <= duty_lo;
                     // An empty range finishes at once without ramping.
                     if (duty_lo >= duty_hi) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= RAMP_UP;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               RAMP_UP: begin
                  if (tick) begin
                     tick_q <= '0;
                     duty_q <= up_d;
                     if (up_d == hi_q) begin
                        state_q <= HOLD_HIGH;
                        hcnt_q  <= '0;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               HOLD_HIGH: begin
                  if (hcnt_q == hold_q) begin
                     state_q <= RAMP_DOWN;
                     tick_q  <= '0;
                     hcnt_q  <= '0;
                  end else begin
                     hcnt_q <= hcnt_q + 1'b1;
                  end
               end
               RAMP_DOWN: begin
                  if (tick) begin
                     tick_q <= '0;
                     duty_q <= dn_d;
                     if (dn_d == lo_q) begin
                        done_q <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
                        if (loop_en) begin
                           state_q <= HOLD_LOW;
                           hcnt_q  <= '0;
                        end else begin
                           state_q <= IDLE;
                           busy_q  <= 1'b0;
                        end
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
`ifdef PWM_FADE_LOOP_EN
               HOLD_LOW: begin
                  if (hcnt_q == hold_q) begin
                     state_q <= RAMP_UP;
                     tick_q  <= '0;
                     hcnt_q  <= '0;
                  end else begin
                     hcnt_q <= hcnt_q + 1'b1;
                  end
               end
`endif
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign duty  = duty_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign state = state_q;

endmodule
